alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8; entry count, power of two, range 2..32.
REQ-002 SHALL have parameter ROB_W, default 5; ROB tag width.
REQ-003 SHALL have parameter TYPE_W, default 5; ALU op-type width.
REQ-004 SHALL have parameter NUM_WB, default 2; number of result-broadcast ports, range 1..4.
REQ-005 SHALL have port clk, input, 1; the single clock.
REQ-006 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1; mispredict clear.
REQ-008 SHALL have port rob_head, input, ROB_W; oldest in-flight tag.
REQ-009 SHALL have ports disp_valid (input, 1) and disp_ready (output, 1); dispatch handshake.
REQ-010 SHALL have ports disp_rob_id (input, ROB_W) and disp_type (input, TYPE_W).
REQ-011 SHALL have ports disp_v1 and disp_v2 (input, 32 each); operand values.
REQ-012 SHALL have ports disp_q1 and disp_q2 (input, 1 each); operand pending.
REQ-013 SHALL have ports disp_dep1 and disp_dep2 (input, ROB_W each); producer tags.
REQ-014 SHALL have ports wb_valid (input, NUM_WB), wb_rob_id (input, NUM_WB*ROB_W) and wb_value (input, NUM_WB*32); port k occupies slice k.
REQ-015 SHALL have ports iss_valid (output, 1) and iss_ready (input, 1); issue handshake, ALU may stall.
REQ-016 SHALL have ports iss_v1 and iss_v2 (output, 32 each), iss_rob_id (output, ROB_W) and iss_type (output, TYPE_W).
REQ-017 SHALL have port count (output, $clog2(DEPTH)+1); occupied entries.

Function
REQ-018 Entry fields SHALL be busy, rob_id, type, v1, v2, q1, q2, dep1, dep2.
REQ-019 disp_ready SHALL equal (count < DEPTH); no same-cycle credit from issue.
REQ-020 Dispatch SHALL be accepted only when disp_valid && disp_ready && !flush, into the lowest-index free entry.
REQ-021 On accept, any operand with q=1 whose dep matches an active wb port in the same cycle SHALL capture that wb_value and clear q.
REQ-022 At every edge, each busy entry SHALL capture wb_value and clear qN for each operand whose qN=1 and depN matches a valid wb port.
REQ-023 When several wb ports match one operand, the lowest port index SHALL win.
REQ-024 An entry SHALL be eligible when busy && !q1 && !q2; wakeup becomes visible one cycle after capture.
REQ-025 Select SHALL choose the eligible entry with minimum (rob_id - rob_head) mod 2^ROB_W; ties SHALL go to the lowest index.
REQ-026 iss_* SHALL be combinational from registered state; iss_valid SHALL be 1 iff an eligible entry exists and flush=0.
REQ-027 On iss_valid && iss_ready the selected entry SHALL be freed at the edge; iss_* SHALL be held stable while iss_ready=0.
REQ-028 count SHALL update as count + accept - issue; simultaneous accept and issue at count=DEPTH SHALL be impossible by REQ-019.
REQ-029 flush SHALL clear all busy and set count to 0 at the next edge, overriding dispatch, wakeup and issue.

Reset
REQ-030 On rst_n=0, asynchronously: all busy, q1 and q2 SHALL be 0 and count SHALL be 0; the payload fields are don't-care.
REQ-031 As a result of reset, iss_valid=0 and disp_ready=1.

Structure
REQ-032 ROB_W, TYPE_W and default DEPTH/NUM_WB SHALL be defined in the shared constants package.
REQ-033 Age select SHALL be a sub-module rs_age_select: a log2(DEPTH)-level tree comparing relative age, outputting valid and index.

Verification
REQ-034 Dispatch tag 3, q1=q2=0 -> iss_valid=1 next cycle with iss_rob_id=3, and the entry is freed on iss_ready=1.
REQ-035 Dispatch with q1=1, dep1=7; wb port 1 broadcasts tag 7 with value 0xDEAD in the same cycle -> entry issues next cycle with iss_v1=0xDEAD.
REQ-036 rob_head=30 (ROB_W=5) with eligible tags 2, 31 and 29 -> issue order 31, 2, 29... wait, relative ages are 1, 4 and 31 for tags 31, 2 and 29 -> issue order 31, 2, 29.
REQ-037 Fill 8 entries with q1=1 -> disp_ready=0, count=8; one wakeup then issue -> disp_ready=1 the cycle after the issue.
REQ-038 Hold iss_ready=0 for 3 cycles -> iss_* stable throughout; flush -> count=0 and iss_valid=0 next cycle.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// alu_issue_queue_pkg: shared widths and default sizes for the ALU issue queue.
// Revision: 1.0
package alu_issue_queue_pkg;
   localparam int IQ_DEPTH  = 8;
   localparam int IQ_ROB_W  = 5;
   localparam int IQ_TYPE_W = 5;
   localparam int IQ_NUM_WB = 2;
   localparam int DATA_W    = 32;
endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// rs_age_select: binary tree picking the valid entry with the smallest relative age.
// Revision: 1.0
module rs_age_select #(
   parameter int DEPTH = 8,
   parameter int AGE_W = 5
) (
   input  logic [DEPTH-1:0]         valid,
   input  logic [DEPTH*AGE_W-1:0]   age,
   output logic                     sel_valid,
   output logic [$clog2(DEPTH)-1:0] sel_idx
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int NODES = 2 * DEPTH - 1;

   // Heap layout: node n has children 2n+1 (lower indices) and 2n+2.
   logic             nv [NODES];
   logic [AGE_W-1:0] na [NODES];
   logic [IDX_W-1:0] ni [NODES];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         nv[DEPTH-1+i] = valid[i];
         na[DEPTH-1+i] = age[i*AGE_W +: AGE_W];
         ni[DEPTH-1+i] = IDX_W'(i);
      end
      // Left wins equal ages, so ties resolve to the lowest index.
      for (int n = DEPTH - 2; n >= 0; n--) begin
         if (nv[2*n+1] && (!nv[2*n+2] || na[2*n+1] <= na[2*n+2])) begin
            nv[n] = 1'b1;
            na[n] = na[2*n+1];
            ni[n] = ni[2*n+1];
         end else begin
            nv[n] = nv[2*n+2];
            na[n] = na[2*n+2];
            ni[n] = ni[2*n+2];
         end
      end
      sel_valid = nv[0];
      sel_idx   = ni[0];
   end
endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// alu_issue_queue: reservation station with result wakeup and oldest-first issue.
// Revision: 1.0
module alu_issue_queue
   import alu_issue_queue_pkg::*;
#(
   parameter int DEPTH  = IQ_DEPTH,
   parameter int ROB_W  = IQ_ROB_W,
   parameter int TYPE_W = IQ_TYPE_W,
   parameter int NUM_WB = IQ_NUM_WB
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [ROB_W-1:0]         rob_head,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [ROB_W-1:0]         disp_rob_id,
   input  logic [TYPE_W-1:0]        disp_type,
   input  logic [DATA_W-1:0]        disp_v1,
   input  logic [DATA_W-1:0]        disp_v2,
   input  logic                     disp_q1,
   input  logic                     disp_q2,
   input  logic [ROB_W-1:0]         disp_dep1,
   input  logic [ROB_W-1:0]         disp_dep2,
   input  logic [NUM_WB-1:0]        wb_valid,
   input  logic [NUM_WB*ROB_W-1:0]  wb_rob_id,
   input  logic [NUM_WB*DATA_W-1:0] wb_value,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic [DATA_W-1:0]        iss_v1,
   output logic [DATA_W-1:0]        iss_v2,
   output logic [ROB_W-1:0]         iss_rob_id,
   output logic [TYPE_W-1:0]        iss_type,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]  busy, q1, q2;
   logic [ROB_W-1:0]  rob_id [DEPTH];
   logic [ROB_W-1:0]  dep1   [DEPTH];
   logic [ROB_W-1:0]  dep2   [DEPTH];
   logic [TYPE_W-1:0] op_type[DEPTH];
   logic [DATA_W-1:0] v1     [DEPTH];
   logic [DATA_W-1:0] v2     [DEPTH];

   logic              hold_valid;
   logic [IDX_W-1:0]  hold_idx;

   logic [DEPTH-1:0]  hit1, hit2;
   logic [DATA_W-1:0] wv1 [DEPTH];
   logic [DATA_W-1:0] wv2 [DEPTH];
   logic              d_hit1, d_hit2;
   logic [DATA_W-1:0] d_wv1, d_wv2;

   logic [DEPTH-1:0]       eligible;
   logic [DEPTH*ROB_W-1:0] rel_age;
   logic                   sel_valid;
   logic [IDX_W-1:0]       sel_idx, cur_idx, free_idx;
   logic                   accept, issue;

   // Ports are scanned from the highest index down so the lowest matching port wins.
   always_comb begin
      d_hit1 = 1'b0;
      d_hit2 = 1'b0;
      d_wv1  = disp_v1;
      d_wv2  = disp_v2;
      for (int i = 0; i < DEPTH; i++) begin
         hit1[i] = 1'b0;
         hit2[i] = 1'b0;
         wv1[i]  = v1[i];
         wv2[i]  = v2[i];
      end
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         if (wb_valid[k]) begin
            if (wb_rob_id[k*ROB_W +: ROB_W] == disp_dep1) begin
               d_hit1 = 1'b1;
               d_wv1  = wb_value[k*DATA_W +: DATA_W];
            end
            if (wb_rob_id[k*ROB_W +: ROB_W] == disp_dep2) begin
               d_hit2 = 1'b1;
               d_wv2  = wb_value[k*DATA_W +: DATA_W];
            end
            for (int i = 0; i < DEPTH; i++) begin
               if (wb_rob_id[k*ROB_W +: ROB_W] == dep1[i]) begin
                  hit1[i] = 1'b1;
                  wv1[i]  = wb_value[k*DATA_W +: DATA_W];
               end
               if (wb_rob_id[k*ROB_W +: ROB_W] == dep2[i]) begin
                  hit2[i] = 1'b1;
                  wv2[i]  = wb_value[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = IDX_W'(i);
      end
      eligible = busy & ~q1 & ~q2;
      for (int i = 0; i < DEPTH; i++) begin
         rel_age[i*ROB_W +: ROB_W] = rob_id[i] - rob_head;
      end
   end

   rs_age_select #(
      .DEPTH (DEPTH),
      .AGE_W (ROB_W)
   ) u_age_select (
      .valid     (eligible),
      .age       (rel_age),
      .sel_valid (sel_valid),
      .sel_idx   (sel_idx)
   );

   // A stalled issue stays locked on its entry so iss_* cannot change under the ALU.
   assign cur_idx    = hold_valid ? hold_idx : sel_idx;
   assign iss_valid  = (hold_valid | sel_valid) & ~flush;
   assign issue      = iss_valid & iss_ready;
   assign disp_ready = count < CNT_W'(DEPTH);
   assign accept     = disp_valid & disp_ready & ~flush;

   assign iss_rob_id = rob_id[cur_idx];
   assign iss_type   = op_type[cur_idx];
   assign iss_v1     = v1[cur_idx];
   assign iss_v2     = v2[cur_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         q1         <= '0;
         q2         <= '0;
         count      <= '0;
         hold_valid <= 1'b0;
         hold_idx   <= '0;
      end else if (flush) begin
         busy       <= '0;
         count      <= '0;
         hold_valid <= 1'b0;
      end else begin
         count      <= count + CNT_W'(accept) - CNT_W'(issue);
         hold_valid <= iss_valid & ~iss_ready;
         hold_idx   <= cur_idx;
         for (int i = 0; i < DEPTH; i++) begin
            if (q1[i] && hit1[i]) q1[i] <= 1'b0;
            if (q2[i] && hit2[i]) q2[i] <= 1'b0;
            if (issue && cur_idx == IDX_W'(i)) busy[i] <= 1'b0;
            if (accept && free_idx == IDX_W'(i)) begin
               busy[i] <= 1'b1;
               q1[i]   <= disp_q1 & ~d_hit1;
               q2[i]   <= disp_q2 & ~d_hit2;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (accept && free_idx == IDX_W'(i)) begin
            rob_id[i]  <= disp_rob_id;
            op_type[i] <= disp_type;
            dep1[i]    <= disp_dep1;
            dep2[i]    <= disp_dep2;
            v1[i]      <= (disp_q1 && d_hit1) ? d_wv1 : disp_v1;
            v2[i]      <= (disp_q2 && d_hit2) ? d_wv2 : disp_v2;
         end else begin
            if (q1[i] && hit1[i]) v1[i] <= wv1[i];
            if (q2[i] && hit2[i]) v2[i] <= wv2[i];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// tb_alu_issue_queue: directed and random traffic checked by a queue-based reference model.
// Revision: 1.0
`timescale 1ns/1ps
module tb_alu_issue_queue;
   localparam int DEPTH  = 8;
   localparam int ROB_W  = 5;
   localparam int TYPE_W = 5;
   localparam int NUM_WB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush, disp_valid, disp_ready, disp_q1, disp_q2, iss_valid, iss_ready;
   logic [ROB_W-1:0]  rob_head, disp_rob_id, disp_dep1, disp_dep2, iss_rob_id;
   logic [TYPE_W-1:0] disp_type, iss_type;
   logic [31:0]       disp_v1, disp_v2, iss_v1, iss_v2;
   logic [NUM_WB-1:0]       wb_valid;
   logic [NUM_WB*ROB_W-1:0] wb_rob_id;
   logic [NUM_WB*32-1:0]    wb_value;
   logic [$clog2(DEPTH):0]  count;

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .NUM_WB(NUM_WB)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob_id(disp_rob_id),
      .disp_type(disp_type), .disp_v1(disp_v1), .disp_v2(disp_v2),
      .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_dep1(disp_dep1), .disp_dep2(disp_dep2),
      .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_v1(iss_v1), .iss_v2(iss_v2),
      .iss_rob_id(iss_rob_id), .iss_type(iss_type), .count(count)
   );

   typedef struct {
      logic [4:0] rob; logic [4:0] typ; logic [31:0] v1; logic [31:0] v2;
      logic q1; logic q2; logic [4:0] dep1; logic [4:0] dep2;
   } ent_t;
   typedef struct { logic [4:0] rob; logic [4:0] typ; logic [31:0] v1; logic [31:0] v2; } iss_t;
   typedef struct { int cnt; bit vld; } st_t;

   ent_t mq[$];
   iss_t iss_q[$];
   st_t  st_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   started = 1'b0;
   bit   held = 1'b0;
   logic [4:0] held_tag = '0;
   logic [4:0] next_tag = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit wake(input logic [4:0] dep, output logic [31:0] val);
      val = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_valid[k] && wb_rob_id[k*ROB_W +: ROB_W] == dep) begin
            val = wb_value[k*32 +: 32];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit in_model(input logic [4:0] tag);
      foreach (mq[i]) if (mq[i].rob == tag) return 1'b1;
      return 1'b0;
   endfunction

   // Reference model: one call per clock with the inputs already applied.
   task automatic model_step();
      int n = mq.size();
      int pres = -1;
      logic [4:0] best = '1;
      logic [31:0] val;
      ent_t e;
      st_t s;
      iss_t r;
      if (!flush) begin
         if (held) begin
            foreach (mq[i]) if (mq[i].rob == held_tag) pres = i;
         end else begin
            foreach (mq[i]) begin
               logic [4:0] a = mq[i].rob - rob_head;
               if (!mq[i].q1 && !mq[i].q2 && (pres < 0 || a < best)) begin
                  pres = i;
                  best = a;
               end
            end
         end
      end
      s.cnt = n;
      s.vld = (pres >= 0);
      st_q.push_back(s);
      if (pres >= 0) begin
         r.rob = mq[pres].rob; r.typ = mq[pres].typ; r.v1 = mq[pres].v1; r.v2 = mq[pres].v2;
         iss_q.push_back(r);
      end
      if (flush) begin
         mq.delete();
         held = 1'b0;
      end else begin
         if (pres >= 0 && !iss_ready) begin
            held = 1'b1;
            held_tag = mq[pres].rob;
         end else begin
            held = 1'b0;
            if (pres >= 0) mq.delete(pres);
         end
         foreach (mq[i]) begin
            if (mq[i].q1 && wake(mq[i].dep1, val)) begin mq[i].q1 = 1'b0; mq[i].v1 = val; end
            if (mq[i].q2 && wake(mq[i].dep2, val)) begin mq[i].q2 = 1'b0; mq[i].v2 = val; end
         end
         if (disp_valid && n < DEPTH) begin
            e.rob = disp_rob_id; e.typ = disp_type; e.v1 = disp_v1; e.v2 = disp_v2;
            e.q1 = disp_q1; e.q2 = disp_q2; e.dep1 = disp_dep1; e.dep2 = disp_dep2;
            if (e.q1 && wake(e.dep1, val)) begin e.q1 = 1'b0; e.v1 = val; end
            if (e.q2 && wake(e.dep2, val)) begin e.q2 = 1'b0; e.v2 = val; end
            mq.push_back(e);
         end
      end
   endtask

   task automatic idle();
      flush = 1'b0; disp_valid = 1'b0; disp_rob_id = '0; disp_type = '0;
      disp_v1 = '0; disp_v2 = '0; disp_q1 = 1'b0; disp_q2 = 1'b0;
      disp_dep1 = '0; disp_dep2 = '0; wb_valid = '0; wb_rob_id = '0; wb_value = '0;
      iss_ready = 1'b1;
   endtask

   task automatic set_disp(input logic [4:0] tag, input logic [4:0] typ, input logic [31:0] a,
                           input logic [31:0] b, input logic qa, input logic [4:0] da,
                           input logic qb, input logic [4:0] db);
      disp_valid = 1'b1; disp_rob_id = tag; disp_type = typ; disp_v1 = a; disp_v2 = b;
      disp_q1 = qa; disp_dep1 = da; disp_q2 = qb; disp_dep2 = db;
   endtask

   task automatic set_wb(input int k, input logic [4:0] tag, input logic [31:0] val);
      wb_valid[k] = 1'b1;
      wb_rob_id[k*ROB_W +: ROB_W] = tag;
      wb_value[k*32 +: 32] = val;
   endtask

   task automatic tick();
      #1 model_step();
      @(negedge clk);
   endtask

   initial begin : monitor
      st_t s;
      iss_t e;
      forever begin
         @(negedge clk);
         #2;
         if (started) begin
            if (st_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL status_queue: got empty expected one entry");
               s.cnt = 0; s.vld = 1'b0;
            end else begin
               s = st_q.pop_front();
               chk("count", 32'(count), 32'(s.cnt));
               chk("disp_ready", 32'(disp_ready), 32'(s.cnt < DEPTH));
               chk("iss_valid", 32'(iss_valid), 32'(s.vld));
            end
            if (iss_valid) begin
               if (iss_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_issue: got tag %0d expected none", iss_rob_id);
               end else begin
                  e = iss_q.pop_front();
                  chk("iss_rob_id", 32'(iss_rob_id), 32'(e.rob));
                  chk("iss_type", 32'(iss_type), 32'(e.typ));
                  chk("iss_v1", iss_v1, e.v1);
                  chk("iss_v2", iss_v2, e.v2);
               end
            end else if (s.vld && iss_q.size() != 0) begin
               void'(iss_q.pop_front());
            end
         end
      end
   end

   initial begin : driver
      idle();
      rob_head = '0;
      #12;
      chk("reset_iss_valid", 32'(iss_valid), 32'd0);
      chk("reset_disp_ready", 32'(disp_ready), 32'd1);
      chk("reset_count", 32'(count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      started = 1'b1;

      // Single ready op issues the next cycle.
      set_disp(5'd3, 5'd1, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0); tick();
      idle(); tick();
      idle(); tick();

      // Same-cycle capture from port 1.
      set_disp(5'd4, 5'd2, 32'h0, 32'h33, 1'b1, 5'd7, 1'b0, 5'd0);
      set_wb(0, 5'd6, 32'hBEEF); set_wb(1, 5'd7, 32'hDEAD); tick();
      idle(); tick();
      idle(); tick();

      // Age order around the head wrap, with both ports matching one tag.
      rob_head = 5'd30;
      idle(); set_disp(5'd2, 5'd3, 32'h0, 32'h2, 1'b1, 5'd5, 1'b0, 5'd0); tick();
      idle(); set_disp(5'd31, 5'd4, 32'h0, 32'h31, 1'b1, 5'd5, 1'b0, 5'd0); tick();
      idle(); set_disp(5'd29, 5'd5, 32'h0, 32'h29, 1'b1, 5'd5, 1'b0, 5'd0); tick();
      idle(); set_wb(0, 5'd5, 32'h55); set_wb(1, 5'd5, 32'h66); tick();
      for (int i = 0; i < 4; i++) begin idle(); tick(); end

      // Fill to capacity, reject extra dispatch, free one slot.
      rob_head = 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         set_disp(5'(10 + i), 5'(i), 32'(i), 32'(100 + i), 1'b1, (i == 0) ? 5'd20 : 5'd21, 1'b0, 5'd0);
         tick();
      end
      idle(); set_disp(5'd18, 5'd9, 32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0); tick();
      idle(); set_wb(1, 5'd20, 32'hCAFE); tick();
      idle(); tick();
      idle(); tick();

      // Stall with a head change underneath, then flush overriding dispatch.
      idle(); iss_ready = 1'b0; set_wb(0, 5'd21, 32'h2121); tick();
      idle(); iss_ready = 1'b0; tick();
      for (int i = 0; i < 3; i++) begin idle(); iss_ready = 1'b0; rob_head = 5'd15; tick(); end
      idle(); iss_ready = 1'b0; flush = 1'b1;
      set_disp(5'd19, 5'd1, 32'h5, 32'h6, 1'b0, 5'd0, 1'b0, 5'd0); tick();
      idle(); rob_head = 5'd0; tick();
      idle(); tick();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         idle();
         if ($urandom_range(0, 49) == 0) flush = 1'b1;
         if ($urandom_range(0, 15) == 0) rob_head = 5'($urandom_range(0, 31));
         iss_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 7) begin
            while (in_model(next_tag)) next_tag = next_tag + 5'd1;
            set_disp(next_tag, 5'($urandom_range(0, 31)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            next_tag = next_tag + 5'd1;
         end
         for (int k = 0; k < NUM_WB; k++) begin
            if ($urandom_range(0, 1) == 1) set_wb(k, 5'($urandom_range(0, 7)), $urandom);
         end
         tick();
      end

      started = 1'b0;
      idle();
      #5;
      chk("issue_queue_drained", 32'(iss_q.size()), 32'd0);
      chk("status_queue_drained", 32'(st_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
